// File: rtl/wb_ahb_pkg.sv
// Shared AHB-Lite encodings and bridge FSM states for the Wishbone-to-AHB bridge.
package wb_ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY    = 2'b00;
  localparam logic [1:0] HRESP_ERROR   = 2'b01;
  localparam logic [1:0] HRESP_RETRY   = 2'b10;
  localparam logic [1:0] HRESP_SPLIT   = 2'b11;

  localparam logic [2:0] HSIZE_BYTE    = 3'b000;
  localparam logic [2:0] HSIZE_HALF    = 3'b001;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HSIZE_DWORD   = 3'b011;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_RESP
  } state_t;

endpackage

// File: rtl/wb_ahb_bridge_if.sv
// Wishbone slave side and AHB-Lite master side of the bridge; one instance may carry both.
interface wb_ahb_bridge_if #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
);

  logic                  cyc_i;
  logic                  stb_i;
  logic                  we_i;
  logic [DWIDTH/8-1:0]   sel_i;
  logic [AWIDTH-1:0]     addr_i;
  logic [DWIDTH-1:0]     data_i;
  logic [DWIDTH-1:0]     data_o;
  logic                  ack_o;
  logic                  err_o;

  logic [AWIDTH-1:0]     haddr;
  logic [1:0]            htrans;
  logic                  hwrite;
  logic [2:0]            hsize;
  logic [2:0]            hburst;
  logic [DWIDTH-1:0]     hwdata;
  logic [DWIDTH-1:0]     hrdata;
  logic                  hready;
  logic [1:0]            hresp;

  modport wb_slave (
    input  cyc_i, stb_i, we_i, sel_i, addr_i, data_i,
    output data_o, ack_o, err_o
  );

  modport wb_master (
    output cyc_i, stb_i, we_i, sel_i, addr_i, data_i,
    input  data_o, ack_o, err_o
  );

  modport ahb_master (
    output haddr, htrans, hwrite, hsize, hburst, hwdata,
    input  hrdata, hready, hresp
  );

  modport ahb_slave (
    input  haddr, htrans, hwrite, hsize, hburst, hwdata,
    output hrdata, hready, hresp
  );

endinterface

// File: rtl/wb_ahb_sel_decode.sv
// Combinational byte-select decode: legality, HSIZE and the low address bits of the lowest lane.
module wb_ahb_sel_decode
  import wb_ahb_pkg::*;
#(
  parameter int DWIDTH = 32
) (
  input  logic [DWIDTH/8-1:0]         sel,
  output logic                        legal,
  output logic [2:0]                  hsize,
  output logic [$clog2(DWIDTH/8)-1:0] lsb
);

  localparam int NB = DWIDTH / 8;
  localparam int LW = $clog2(NB);

  // Later matches override earlier ones; the patterns are disjoint anyway.
  always_comb begin
    legal = 1'b0;
    hsize = HSIZE_WORD;
    lsb   = '0;
    for (int i = 0; i < NB; i++) begin
      if (sel == (NB'(1) << i)) begin
        legal = 1'b1;
        hsize = HSIZE_BYTE;
        lsb   = LW'(i);
      end
    end
    for (int i = 0; i < NB; i += 2) begin
      if (sel == (NB'(3) << i)) begin
        legal = 1'b1;
        hsize = HSIZE_HALF;
        lsb   = LW'(i);
      end
    end
    for (int i = 0; i < NB; i += 4) begin
      if (sel == (NB'(15) << i)) begin
        legal = 1'b1;
        hsize = HSIZE_WORD;
        lsb   = LW'(i);
      end
    end
    if (NB == 8 && sel == '1) begin
      legal = 1'b1;
      hsize = HSIZE_DWORD;
      lsb   = '0;
    end
  end

endmodule

// File: rtl/wb_ahb_bridge.sv
// Wishbone classic slave to AHB-Lite master: one NONSEQ SINGLE per cycle, 3 clocks stb-to-ack at zero wait.
// AHB hready stalls the FSM; a dropped cyc/stb lets the bus transfer finish silently.
module wb_ahb_bridge
  import wb_ahb_pkg::*;
#(
  parameter int AWIDTH    = 32,
  parameter int DWIDTH    = 32,
  parameter int RETRY_MAX = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  wb_ahb_bridge_if.wb_slave   wb,
  wb_ahb_bridge_if.ahb_master ahb
);

  localparam int NB = DWIDTH / 8;
  localparam int LW = $clog2(NB);
  localparam int CW = $clog2(RETRY_MAX + 2);
  localparam logic [CW-1:0]     RMAX     = CW'(RETRY_MAX);
  localparam logic [AWIDTH-1:0] LOW_MASK = AWIDTH'((1 << LW) - 1);

  state_t              state;
  logic [CW-1:0]       retry_cnt;
  logic                abort_q;
  logic [AWIDTH-1:0]   haddr_q;
  logic [1:0]          htrans_q;
  logic                hwrite_q;
  logic [2:0]          hsize_q;
  logic [DWIDTH-1:0]   hwdata_q;
  logic [DWIDTH-1:0]   data_q;
  logic                ack_q;
  logic                err_q;

  logic                sel_legal;
  logic [2:0]          sel_hsize;
  logic [LW-1:0]       sel_lsb;
  logic                req;
  logic                drop;
  logic                resp_ok;
  logic                finish;

  wb_ahb_sel_decode #(.DWIDTH(DWIDTH)) u_sel_decode (
    .sel   (wb.sel_i),
    .legal (sel_legal),
    .hsize (sel_hsize),
    .lsb   (sel_lsb)
  );

  assign req     = wb.cyc_i & wb.stb_i;
  assign drop    = abort_q | ~req;
  assign resp_ok = (ahb.hresp == HRESP_OKAY);
  // RETRY/SPLIT reissues only while budget remains and the master still waits.
  assign finish  = resp_ok || (ahb.hresp == HRESP_ERROR) || drop || (retry_cnt >= RMAX);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= ST_IDLE;
      retry_cnt <= '0;
      abort_q   <= 1'b0;
      haddr_q   <= '0;
      htrans_q  <= HTRANS_IDLE;
      hwrite_q  <= 1'b0;
      hsize_q   <= HSIZE_WORD;
      hwdata_q  <= '0;
      data_q    <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          abort_q <= 1'b0;
          if (req) begin
            if (sel_legal) begin
              haddr_q  <= (wb.addr_i & ~LOW_MASK) | AWIDTH'(sel_lsb);
              hwrite_q <= wb.we_i;
              hsize_q  <= sel_hsize;
              hwdata_q <= wb.data_i;
              htrans_q <= HTRANS_NONSEQ;
              state    <= ST_ADDR;
            end else begin
              err_q <= 1'b1;
              state <= ST_RESP;
            end
          end
        end
        ST_ADDR: begin
          if (!req) abort_q <= 1'b1;
          if (ahb.hready) begin
            htrans_q <= HTRANS_IDLE;
            state    <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (!req) abort_q <= 1'b1;
          if (ahb.hready) begin
            if (finish) begin
              retry_cnt <= '0;
              if (drop) begin
                state <= ST_IDLE;
              end else begin
                ack_q <= resp_ok;
                err_q <= ~resp_ok;
                if (resp_ok && !hwrite_q) data_q <= ahb.hrdata;
                state <= ST_RESP;
              end
            end else begin
              retry_cnt <= retry_cnt + 1'b1;
              htrans_q  <= HTRANS_NONSEQ;
              state     <= ST_ADDR;
            end
          end
        end
        ST_RESP: begin
          retry_cnt <= '0;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign ahb.haddr  = haddr_q;
  assign ahb.htrans = htrans_q;
  assign ahb.hwrite = hwrite_q;
  assign ahb.hsize  = hsize_q;
  assign ahb.hburst = HBURST_SINGLE;
  assign ahb.hwdata = hwdata_q;
  assign wb.data_o  = data_q;
  assign wb.ack_o   = ack_q;
  assign wb.err_o   = err_q;

endmodule

// File: tb/tb_wb_ahb_bridge.sv
// Scripted bench for a 32-bit (RETRY_MAX=2) and a 64-bit bridge; Wishbone terminations go through a scoreboard.
module tb_wb_ahb_bridge;
  import wb_ahb_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_ahb_bridge_if #(.AWIDTH(32), .DWIDTH(32)) b32();
  wb_ahb_bridge_if #(.AWIDTH(32), .DWIDTH(64)) b64();

  wb_ahb_bridge #(.AWIDTH(32), .DWIDTH(32), .RETRY_MAX(2)) dut32 (
    .clk_i (clk), .rst_i (rst), .wb (b32), .ahb (b32)
  );
  wb_ahb_bridge #(.AWIDTH(32), .DWIDTH(64), .RETRY_MAX(4)) dut64 (
    .clk_i (clk), .rst_i (rst), .wb (b64), .ahb (b64)
  );

  int n_cmp = 0;
  int n_mis = 0;

  typedef struct packed {
    logic        err;
    logic        chk_d;
    logic [63:0] d;
  } exp_t;

  exp_t q32[$];
  exp_t q64[$];
  exp_t e32;
  exp_t e64;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_mis++;
      $display("FAIL %s: got %0h want %0h", tag, act, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req32(input logic [31:0] a, input logic [3:0] s, input logic w, input logic [31:0] d);
    b32.cyc_i = 1'b1; b32.stb_i = 1'b1; b32.we_i = w;
    b32.sel_i = s;    b32.addr_i = a;   b32.data_i = d;
  endtask

  task automatic req64(input logic [31:0] a, input logic [7:0] s, input logic w, input logic [63:0] d);
    b64.cyc_i = 1'b1; b64.stb_i = 1'b1; b64.we_i = w;
    b64.sel_i = s;    b64.addr_i = a;   b64.data_i = d;
  endtask

  task automatic idle32();
    b32.cyc_i = 1'b0; b32.stb_i = 1'b0;
  endtask

  task automatic idle64();
    b64.cyc_i = 1'b0; b64.stb_i = 1'b0;
  endtask

  task automatic chk_reset32(input string tag);
    chk({tag, " htrans"}, 64'(b32.htrans), 64'(HTRANS_IDLE));
    chk({tag, " haddr"},  64'(b32.haddr),  64'h0);
    chk({tag, " hwrite"}, 64'(b32.hwrite), 64'h0);
    chk({tag, " hsize"},  64'(b32.hsize),  64'(3'b010));
    chk({tag, " hburst"}, 64'(b32.hburst), 64'h0);
    chk({tag, " hwdata"}, 64'(b32.hwdata), 64'h0);
    chk({tag, " data_o"}, 64'(b32.data_o), 64'h0);
    chk({tag, " ack_o"},  64'(b32.ack_o),  64'h0);
    chk({tag, " err_o"},  64'(b32.err_o),  64'h0);
  endtask

  // Scoreboards: every termination pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (b32.ack_o || b32.err_o) begin
      if (q32.size() == 0) begin
        chk("sb32 spurious term", 64'h1, 64'h0);
      end else begin
        e32 = q32.pop_front();
        chk("sb32 err_o", 64'(b32.err_o), 64'(e32.err));
        chk("sb32 ack_o", 64'(b32.ack_o), 64'(!e32.err));
        if (e32.chk_d) chk("sb32 data_o", 64'(b32.data_o), e32.d);
      end
    end
    if (b64.ack_o || b64.err_o) begin
      if (q64.size() == 0) begin
        chk("sb64 spurious term", 64'h1, 64'h0);
      end else begin
        e64 = q64.pop_front();
        chk("sb64 err_o", 64'(b64.err_o), 64'(e64.err));
        chk("sb64 ack_o", 64'(b64.ack_o), 64'(!e64.err));
        if (e64.chk_d) chk("sb64 data_o", b64.data_o, e64.d);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    idle32(); b32.we_i = 1'b0; b32.sel_i = '0; b32.addr_i = '0; b32.data_i = '0;
    b32.hready = 1'b1; b32.hresp = HRESP_OKAY; b32.hrdata = '0;
    idle64(); b64.we_i = 1'b0; b64.sel_i = '0; b64.addr_i = '0; b64.data_i = '0;
    b64.hready = 1'b1; b64.hresp = HRESP_OKAY; b64.hrdata = '0;
    tick(); tick();
    rst = 1'b0;
    chk_reset32("reset");
    chk("reset hsize64", 64'(b64.hsize), 64'(3'b010));
    tick();

    // Zero-wait word write
    req32(32'h100, 4'hF, 1'b1, 32'hDEADBEEF);
    q32.push_back('{1'b0, 1'b0, 64'h0});
    tick();
    chk("t1 htrans c1", 64'(b32.htrans), 64'(HTRANS_NONSEQ));
    chk("t1 haddr",     64'(b32.haddr),  64'h100);
    chk("t1 hsize",     64'(b32.hsize),  64'(3'b010));
    chk("t1 hwrite",    64'(b32.hwrite), 64'h1);
    tick();
    chk("t1 htrans c2", 64'(b32.htrans), 64'(HTRANS_IDLE));
    chk("t1 hwdata",    64'(b32.hwdata), 64'hDEADBEEF);
    tick();
    chk("t1 ack c3",    64'(b32.ack_o),  64'h1);
    idle32();
    tick();
    chk("t1 ack pulse", 64'(b32.ack_o),  64'h0);

    // Byte read on lane 2 with two data-phase wait states
    req32(32'h200, 4'b0100, 1'b0, 32'h0);
    q32.push_back('{1'b0, 1'b1, 64'hA5C31E77});
    tick();
    chk("t2 htrans c1", 64'(b32.htrans), 64'(HTRANS_NONSEQ));
    chk("t2 haddr",     64'(b32.haddr),  64'h202);
    chk("t2 hsize",     64'(b32.hsize),  64'(3'b000));
    chk("t2 hwrite",    64'(b32.hwrite), 64'h0);
    tick();
    chk("t2 htrans c2", 64'(b32.htrans), 64'(HTRANS_IDLE));
    b32.hready = 1'b0;
    tick();
    tick();
    chk("t2 ack wait",  64'(b32.ack_o),  64'h0);
    b32.hready = 1'b1; b32.hrdata = 32'hA5C31E77;
    tick();
    chk("t2 ack c5",    64'(b32.ack_o),  64'h1);
    chk("t2 data_o",    64'(b32.data_o), 64'hA5C31E77);
    idle32();
    tick();

    // Two-cycle ERROR response
    req32(32'h300, 4'hF, 1'b1, 32'h11112222);
    q32.push_back('{1'b1, 1'b0, 64'h0});
    tick();
    tick();
    b32.hready = 1'b0; b32.hresp = HRESP_ERROR;
    chk("t3 htrans resp1", 64'(b32.htrans), 64'(HTRANS_IDLE));
    tick();
    b32.hready = 1'b1;
    tick();
    chk("t3 err_o", 64'(b32.err_o), 64'h1);
    chk("t3 ack_o", 64'(b32.ack_o), 64'h0);
    b32.hresp = HRESP_OKAY; idle32();
    tick();
    chk("t3 err pulse", 64'(b32.err_o), 64'h0);

    // Three RETRYs against RETRY_MAX=2: two reissues then error
    req32(32'h400, 4'b0011, 1'b0, 32'h0);
    q32.push_back('{1'b1, 1'b0, 64'h0});
    tick();
    for (int r = 0; r < 3; r++) begin
      chk($sformatf("t4 nonseq%0d", r), 64'(b32.htrans), 64'(HTRANS_NONSEQ));
      chk($sformatf("t4 haddr%0d", r),  64'(b32.haddr),  64'h400);
      tick();
      b32.hready = 1'b0; b32.hresp = HRESP_RETRY;
      tick();
      b32.hready = 1'b1;
      tick();
    end
    chk("t4 err_o",  64'(b32.err_o),  64'h1);
    chk("t4 htrans", 64'(b32.htrans), 64'(HTRANS_IDLE));
    b32.hresp = HRESP_OKAY; idle32();
    tick();

    // One SPLIT after the exhausted budget: a cleared count allows a reissue
    req32(32'h440, 4'hF, 1'b0, 32'h0);
    q32.push_back('{1'b0, 1'b1, 64'h12345678});
    tick();
    tick();
    b32.hready = 1'b0; b32.hresp = HRESP_SPLIT;
    tick();
    b32.hready = 1'b1;
    tick();
    chk("t4b reissue", 64'(b32.htrans), 64'(HTRANS_NONSEQ));
    b32.hresp = HRESP_OKAY; b32.hrdata = 32'h12345678;
    tick();
    tick();
    chk("t4b ack_o", 64'(b32.ack_o), 64'h1);
    idle32();
    tick();

    // Illegal sel: immediate error, bus untouched
    req32(32'h500, 4'b0110, 1'b1, 32'h0);
    q32.push_back('{1'b1, 1'b0, 64'h0});
    tick();
    chk("t5 err_o",  64'(b32.err_o),  64'h1);
    chk("t5 htrans", 64'(b32.htrans), 64'(HTRANS_IDLE));
    idle32();
    tick();
    chk("t5 htrans after", 64'(b32.htrans), 64'(HTRANS_IDLE));

    // 64-bit dword write, then byte read on lane 5
    req64(32'h1000, 8'hFF, 1'b1, 64'h0123456789ABCDEF);
    q64.push_back('{1'b0, 1'b0, 64'h0});
    tick();
    chk("t5b htrans", 64'(b64.htrans), 64'(HTRANS_NONSEQ));
    chk("t5b hsize",  64'(b64.hsize),  64'(3'b011));
    chk("t5b haddr",  64'(b64.haddr),  64'h1000);
    tick();
    chk("t5b hwdata", b64.hwdata, 64'h0123456789ABCDEF);
    tick();
    chk("t5b ack_o",  64'(b64.ack_o),  64'h1);
    idle64();
    tick();
    req64(32'h2000, 8'h20, 1'b0, 64'h0);
    b64.hrdata = 64'hCAFEF00D8BADF00D;
    q64.push_back('{1'b0, 1'b1, 64'hCAFEF00D8BADF00D});
    tick();
    chk("t5c haddr", 64'(b64.haddr), 64'h2005);
    chk("t5c hsize", 64'(b64.hsize), 64'(3'b000));
    tick();
    tick();
    chk("t5c ack_o", 64'(b64.ack_o), 64'h1);
    idle64();
    tick();

    // Reset pulsed while the data phase is stalled
    req32(32'h600, 4'hF, 1'b1, 32'h55AA55AA);
    tick();
    tick();
    b32.hready = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0; b32.hready = 1'b1; idle32();
    chk_reset32("t6a");
    tick();

    // Strobe dropped in a stalled address phase: transfer completes silently
    req32(32'h700, 4'hF, 1'b0, 32'h0);
    tick();
    b32.hready = 1'b0; idle32();
    tick();
    chk("t6b nonseq held", 64'(b32.htrans), 64'(HTRANS_NONSEQ));
    b32.hready = 1'b1;
    tick();
    chk("t6b htrans data", 64'(b32.htrans), 64'(HTRANS_IDLE));
    tick();
    chk("t6b ack_o",  64'(b32.ack_o),  64'h0);
    chk("t6b err_o",  64'(b32.err_o),  64'h0);
    chk("t6b htrans", 64'(b32.htrans), 64'(HTRANS_IDLE));
    tick();
    tick();
    chk("pending q32", 64'(q32.size()), 64'h0);
    chk("pending q64", 64'(q64.size()), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
